// File: rtl/updown_count_pkg.sv
// Shared types for counter monitors: direction states, event codes and
// the per-sample transition classification.
package updown_count_pkg;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    typedef enum logic [2:0] {
        EVT_NONE    = 3'd0,
        EVT_JUMP    = 3'd1,
        EVT_DIR_CHG = 3'd2,
        EVT_WRAP_UP = 3'd3,
        EVT_WRAP_DN = 3'd4
    } evt_code_e;

    typedef enum logic [2:0] {
        CLS_HOLD,
        CLS_STEP_UP,
        CLS_WRAP_UP,
        CLS_STEP_DN,
        CLS_WRAP_DN,
        CLS_JUMP
    } cls_e;

    function automatic logic cls_is_up(input cls_e c);
        return (c == CLS_STEP_UP) || (c == CLS_WRAP_UP);
    endfunction

    function automatic logic cls_is_dn(input cls_e c);
        return (c == CLS_STEP_DN) || (c == CLS_WRAP_DN);
    endfunction

endpackage

// File: rtl/count_event_fifo.sv
// Synchronous FIFO for monitor events; head is read combinationally so a
// push into an empty FIFO is visible the following cycle.
module count_event_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being popped this cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];
    assign level    = level_q;

endmodule

// File: rtl/updown_count_monitor.sv
// Watches an up/down counter, classifies each sampled transition and
// queues jump / direction-change / wrap events for a downstream reader.
//
// state | meaning
// IDLE  | no step observed since reset
// UP    | last step was upward
// DOWN  | last step was downward
module updown_count_monitor
    import updown_count_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     count_vld,
    output logic [1:0]               dir,
    output logic [WRAP_W-1:0]        wrap_cnt,
    output logic                     err,
    output logic                     ovf,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [2:0]               evt_code,
    output logic [WIDTH-1:0]         evt_val,
    output logic [$clog2(DEPTH):0]   evt_level
);
    localparam logic [1:0] ST_IDLE = DIR_IDLE;
    localparam logic [1:0] ST_UP   = DIR_UP;
    localparam logic [1:0] ST_DOWN = DIR_DOWN;
    localparam int         DW      = 3 + WIDTH;

    logic [WIDTH-1:0] prev;
    logic             prev_ok;
    logic [WIDTH-1:0] delta;
    cls_e             cls;
    logic             classify;
    logic             dir_chg;
    logic             is_wrap;
    logic [1:0]       dir_q;
    logic [1:0]       dir_nxt;
    logic             evt_push;
    evt_code_e        push_code;
    logic             fifo_full;
    logic             fifo_empty;
    logic             evt_pop;
    logic [DW-1:0]    head;

    assign classify = count_vld && prev_ok;

    always_comb begin
        delta = count_in - prev;
        cls   = CLS_JUMP;
        if (delta == '0)
            cls = CLS_HOLD;
        else if (delta == WIDTH'(1))
            cls = (prev == '1) ? CLS_WRAP_UP : CLS_STEP_UP;
        else if (delta == '1)
            cls = (prev == '0) ? CLS_WRAP_DN : CLS_STEP_DN;
    end

    always_comb begin
        dir_nxt = dir_q;
        dir_chg = 1'b0;
        if (cls_is_up(cls)) begin
            dir_nxt = ST_UP;
            dir_chg = (dir_q == ST_DOWN);
        end else if (cls_is_dn(cls)) begin
            dir_nxt = ST_DOWN;
            dir_chg = (dir_q == ST_UP);
        end
    end

    assign is_wrap = (cls == CLS_WRAP_UP) || (cls == CLS_WRAP_DN);

    // One event per sample: jump outranks direction change outranks wrap.
    always_comb begin
        evt_push  = 1'b0;
        push_code = EVT_NONE;
        if (classify) begin
            if (cls == CLS_JUMP) begin
                evt_push  = 1'b1;
                push_code = EVT_JUMP;
            end else if (dir_chg) begin
                evt_push  = 1'b1;
                push_code = EVT_DIR_CHG;
            end else if (cls == CLS_WRAP_UP) begin
                evt_push  = 1'b1;
                push_code = EVT_WRAP_UP;
            end else if (cls == CLS_WRAP_DN) begin
                evt_push  = 1'b1;
                push_code = EVT_WRAP_DN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= '0;
            prev_ok  <= 1'b0;
            dir_q    <= ST_IDLE;
            wrap_cnt <= '0;
            err      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (count_vld) begin
                prev    <= count_in;
                prev_ok <= 1'b1;
            end
            if (classify) begin
                dir_q <= dir_nxt;
                if (cls == CLS_JUMP) err <= 1'b1;
                if (is_wrap && (wrap_cnt != '1)) wrap_cnt <= wrap_cnt + 1'b1;
            end
            if (evt_push && fifo_full && !evt_pop) ovf <= 1'b1;
        end
    end

    assign evt_valid = !fifo_empty;
    assign evt_pop   = evt_valid && evt_ready;

    count_event_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (evt_push),
        .push_data ({push_code, count_in}),
        .pop       (evt_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (evt_level)
    );

    assign dir      = dir_q;
    assign evt_code = head[DW-1:WIDTH];
    assign evt_val  = head[WIDTH-1:0];

endmodule

// File: tb/tb_updown_count_monitor.sv
// Directed bench for updown_count_monitor: a vector table for the
// single-cycle behaviour plus hand sequences for back-pressure and reset.
module tb_updown_count_monitor;
    localparam int WIDTH  = 4;
    localparam int DEPTH  = 4;
    localparam int WRAP_W = 8;
    localparam logic [1:0] D_IDLE = 2'd0;
    localparam logic [1:0] D_UP   = 2'd1;
    localparam logic [1:0] D_DN   = 2'd2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] count_in;
    logic             count_vld;
    logic [1:0]       dir;
    logic [WRAP_W-1:0] wrap_cnt;
    logic             err;
    logic             ovf;
    logic             evt_valid;
    logic             evt_ready;
    logic [2:0]       evt_code;
    logic [WIDTH-1:0] evt_val;
    logic [2:0]       evt_level;

    int checks = 0;
    int errors = 0;

    updown_count_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WRAP_W(WRAP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .count_vld (count_vld),
        .dir       (dir),
        .wrap_cnt  (wrap_cnt),
        .err       (err),
        .ovf       (ovf),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_val   (evt_val),
        .evt_level (evt_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [3:0] cnt;
        logic       rdy;
        logic [1:0] e_dir;
        logic [7:0] e_wrap;
        logic       e_err;
        logic       e_valid;
        logic [2:0] e_code;
        logic [3:0] e_val;
    } vec_t;

    vec_t vt[$];

    // Every accepted pop, recorded in order.
    logic [6:0] got [64];
    int         pop_n = 0;

    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready && pop_n < 64) begin
            got[pop_n] <= {evt_code, evt_val};
            pop_n      <= pop_n + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] c, input logic rd);
        rst       = r;
        count_vld = v;
        count_in  = c;
        evt_ready = rd;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic v, input logic [3:0] c,
                                input logic rd, input logic [1:0] d, input logic [7:0] w,
                                input logic e, input logic ev, input logic [2:0] ec,
                                input logic [3:0] evv);
        vec_t x;
        x.rst = r; x.vld = v; x.cnt = c; x.rdy = rd;
        x.e_dir = d; x.e_wrap = w; x.e_err = e;
        x.e_valid = ev; x.e_code = ec; x.e_val = evv;
        vt.push_back(x);
    endfunction

    initial begin
        int base;
        int n;
        rst = 1'b1; count_vld = 1'b0; count_in = '0; evt_ready = 1'b0;

        // Reset, then up count through a wrap (with one unqualified cycle).
        add(1, 0, 0, 1, D_IDLE, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, D_IDLE, 0, 0, 0, 0, 0);
        for (int i = 1; i < 16; i++) begin
            if (i == 8) add(0, 0, 12, 1, D_UP, 0, 0, 0, 0, 0);
            add(0, 1, 4'(i), 1, D_UP, 0, 0, 0, 0, 0);
        end
        add(0, 1, 0, 1, D_UP, 1, 0, 1, 3, 0);
        add(0, 0, 0, 1, D_UP, 1, 0, 0, 0, 0);
        // Direction change then down wrap.
        add(1, 0, 0, 1, D_IDLE, 0, 0, 0, 0, 0);
        add(0, 1, 5, 1, D_IDLE, 0, 0, 0, 0, 0);
        add(0, 1, 6, 1, D_UP, 0, 0, 0, 0, 0);
        add(0, 1, 7, 1, D_UP, 0, 0, 0, 0, 0);
        add(0, 1, 6, 1, D_DN, 0, 0, 1, 2, 6);
        for (int i = 5; i >= 0; i--) add(0, 1, 4'(i), 1, D_DN, 0, 0, 0, 0, 0);
        add(0, 1, 15, 1, D_DN, 1, 0, 1, 4, 15);
        // Down wrap that is also a direction change.
        add(1, 0, 0, 1, D_IDLE, 0, 0, 0, 0, 0);
        add(0, 1, 14, 1, D_IDLE, 0, 0, 0, 0, 0);
        add(0, 1, 15, 1, D_UP, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, D_UP, 1, 0, 1, 3, 0);
        add(0, 1, 15, 1, D_DN, 2, 0, 1, 2, 15);
        add(0, 0, 15, 1, D_DN, 2, 0, 0, 0, 0);
        // Illegal jump; err stays set through legal counting.
        add(1, 0, 0, 1, D_IDLE, 0, 0, 0, 0, 0);
        add(0, 1, 3, 1, D_IDLE, 0, 0, 0, 0, 0);
        add(0, 1, 4, 1, D_UP, 0, 0, 0, 0, 0);
        add(0, 1, 9, 1, D_UP, 0, 1, 1, 1, 9);
        add(0, 1, 10, 1, D_UP, 0, 1, 0, 0, 0);
        add(0, 1, 11, 1, D_UP, 0, 1, 0, 0, 0);

        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].vld, vt[i].cnt, vt[i].rdy);
            check($sformatf("row%0d_dir", i),   dir,       vt[i].e_dir);
            check($sformatf("row%0d_wrap", i),  wrap_cnt,  vt[i].e_wrap);
            check($sformatf("row%0d_err", i),   err,       vt[i].e_err);
            check($sformatf("row%0d_ovf", i),   ovf,       0);
            check($sformatf("row%0d_valid", i), evt_valid, vt[i].e_valid);
            check($sformatf("row%0d_code", i),  evt_code,  vt[i].e_code);
            check($sformatf("row%0d_val", i),   evt_val,   vt[i].e_val);
            check($sformatf("row%0d_level", i), evt_level, vt[i].e_valid ? 1 : 0);
        end

        // Back-pressure: five wraps with the reader stalled.
        step(1, 0, 0, 0);
        base = pop_n;
        step(0, 1, 15, 0);
        step(0, 1, 0, 0);
        step(0, 1, 15, 0);
        for (int i = 14; i >= 0; i--) step(0, 1, 4'(i), 0);
        step(0, 1, 15, 0);
        step(0, 1, 0, 0);
        check("bp_level_full", evt_level, 4);
        check("bp_ovf_before", ovf, 0);
        step(0, 1, 15, 0);
        check("bp_level_hold", evt_level, 4);
        check("bp_ovf", ovf, 1);
        check("bp_wrap", wrap_cnt, 5);
        check("bp_dir", dir, D_DN);
        check("bp_head_code", evt_code, 3);
        check("bp_head_val", evt_val, 0);
        step(0, 1, 0, 1);
        check("bp_pushpop_level", evt_level, 4);
        check("bp_pushpop_wrap", wrap_cnt, 6);
        check("bp_pushpop_dir", dir, D_UP);
        n = 0;
        while (evt_valid && n < 10) begin
            step(0, 0, 0, 1);
            n++;
        end
        check("bp_drain_done", evt_valid, 0);
        check("bp_drain_level", evt_level, 0);
        check("bp_ovf_sticky", ovf, 1);
        check("bp_pop_count", pop_n - base, 5);
        if (pop_n - base == 5) begin
            check("bp_pop0", got[base + 0], {3'd3, 4'd0});
            check("bp_pop1", got[base + 1], {3'd2, 4'd15});
            check("bp_pop2", got[base + 2], {3'd4, 4'd15});
            check("bp_pop3", got[base + 3], {3'd2, 4'd0});
            check("bp_pop4", got[base + 4], {3'd2, 4'd0});
        end

        // Reset with events queued, then qualifier-gated restart.
        step(1, 0, 0, 0);
        step(0, 1, 15, 0);
        step(0, 1, 0, 0);
        step(0, 1, 5, 0);
        check("rst_pre_level", evt_level, 2);
        check("rst_pre_err", err, 1);
        check("rst_pre_wrap", wrap_cnt, 1);
        step(1, 1, 3, 0);
        check("rst_dir", dir, D_IDLE);
        check("rst_wrap", wrap_cnt, 0);
        check("rst_err", err, 0);
        check("rst_ovf", ovf, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_level", evt_level, 0);
        check("rst_code", evt_code, 0);
        check("rst_val", evt_val, 0);
        step(0, 0, 9, 0);
        check("novld_dir", dir, D_IDLE);
        check("novld_level", evt_level, 0);
        step(0, 1, 7, 0);
        check("first_dir", dir, D_IDLE);
        check("first_valid", evt_valid, 0);
        step(0, 1, 8, 0);
        check("restart_dir", dir, D_UP);
        check("restart_err", err, 0);
        check("restart_valid", evt_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
